// File: rtl/matrix_decompiler.sv
// matrix_decompiler: reassembles a dibit stream into tagged matrix elements,
// buffering them in a 4-entry FIFO for a ready/valid downstream consumer.
module matrix_decompiler #(
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_SIZE_A = 32,
  parameter int MAX_SIZE_B = 32
) (
  input  logic                          eth_refclk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          data_request,
  input  logic                          valid_data_in,
  input  logic [1:0]                    dibit,
  output logic [$clog2(MAX_SIZE_A)-1:0] row_addr,
  output logic [$clog2(MAX_SIZE_B)-1:0] col_addr,
  output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
  output logic                          valid_data_out,
  input  logic                          ready_in,
  output logic                          decompile_done,
  output logic                          overflow
);
  localparam int W  = MAX_ELEMENT_SIZE;
  localparam int CB = $clog2(MAX_SIZE_B);
  localparam int IW = $clog2(MAX_SIZE_A * MAX_SIZE_B);
  localparam int EW = IW + W;
  localparam logic [IW-1:0] LAST = IW'(MAX_SIZE_A * MAX_SIZE_B - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [W-1:0]    pend_elem_q, pend_elem_d;
  logic [IW-1:0]   pend_idx_q, pend_idx_d;
  logic [EW-1:0]   mem_q [4];
  logic [EW-1:0]   mem_d [4];
  logic [1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            pop, push;
  logic [EW-1:0]   head;

  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    dcnt_d      = dcnt_q;
    idx_d       = idx_q;
    pend_d      = 1'b0;
    pend_elem_d = pend_elem_q;
    pend_idx_d  = pend_idx_q;
    case (state_q)
      IDLE:    state_d = start ? REQUEST : IDLE;
      REQUEST: state_d = RECEIVE;
      RECEIVE: if (valid_data_in) begin
        asm_d  = {asm_q[W-3:0], dibit};
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          pend_d      = 1'b1;
          pend_elem_d = {asm_q[W-3:0], dibit};
          pend_idx_d  = idx_q;
          idx_d       = idx_q + IW'(1);
          state_d     = (idx_q == LAST) ? DRAIN : RECEIVE;
        end
      end
      DRAIN: if (cnt_q == 3'd0 && !pend_q) begin
        state_d = IDLE;
        idx_d   = '0;
        dcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  always_comb begin
    pop   = (cnt_q != 3'd0) && ready_in;
    push  = pend_q && ((cnt_q != 3'd4) || pop);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {pend_idx_q, pend_elem_q};
    wp_d  = wp_q + 2'(push);
    rp_d  = rp_q + 2'(pop);
    cnt_d = cnt_q + 3'(push) - 3'(pop);
    ovf_d = ovf_q | (pend_q & ~push);
  end

  always_ff @(posedge eth_refclk) begin
    if (!rst) begin
      state_q     <= IDLE;
      asm_q       <= '0;
      dcnt_q      <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_elem_q <= '0;
      pend_idx_q  <= '0;
      mem_q       <= '{default: '0};
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      dcnt_q      <= dcnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_elem_q <= pend_elem_d;
      pend_idx_q  <= pend_idx_d;
      mem_q       <= mem_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign head           = mem_q[rp_q];
  assign row_addr       = head[EW-1:W+CB];
  assign col_addr       = head[W+CB-1:W];
  assign matrix_element = head[W-1:0];
  assign valid_data_out = cnt_q != 3'd0;
  assign data_request   = state_q == REQUEST;
  assign overflow       = ovf_q;
  assign decompile_done = (state_q == DRAIN) && (cnt_q == 3'd0) && !pend_q;
endmodule

// File: tb/tb_matrix_decompiler.sv
// tb_matrix_decompiler: randomized self-checking bench; expected triples are
// derived from the element index and the dibits the bench itself sends.
module tb_matrix_decompiler;
  localparam int A = 32;
  localparam int B = 32;
  localparam int N = A * B;

  logic eth_refclk = 1'b0;
  logic rst = 1'b0, start = 1'b0, valid_data_in = 1'b0, ready_in = 1'b0;
  logic [1:0] dibit = 2'b00;
  logic data_request, valid_data_out, decompile_done, overflow;
  logic [4:0] row_addr, col_addr;
  logic [7:0] matrix_element;

  int checks = 0, failures = 0, done_cnt = 0, req_cnt = 0;
  logic rdy_nxt = 1'b0;
  int got_row[$], got_col[$], got_v[$];

  matrix_decompiler #(.MAX_ELEMENT_SIZE(8), .MAX_SIZE_A(A), .MAX_SIZE_B(B)) dut (
    .eth_refclk(eth_refclk), .rst(rst), .start(start), .data_request(data_request),
    .valid_data_in(valid_data_in), .dibit(dibit), .row_addr(row_addr), .col_addr(col_addr),
    .matrix_element(matrix_element), .valid_data_out(valid_data_out), .ready_in(ready_in),
    .decompile_done(decompile_done), .overflow(overflow)
  );

  always #5 eth_refclk = ~eth_refclk;

  // Drive one cycle of inputs at the falling edge and observe the registered outputs.
  task automatic cyc(input logic vin, input logic [1:0] d, input logic st);
    @(negedge eth_refclk);
    start = st;
    valid_data_in = vin;
    dibit = d;
    ready_in = rdy_nxt;
    if (valid_data_out === 1'b1 && ready_in) begin
      got_row.push_back(int'(row_addr));
      got_col.push_back(int'(col_addr));
      got_v.push_back(int'(matrix_element));
    end
    if (decompile_done === 1'b1) done_cnt++;
    if (data_request === 1'b1) req_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'b00, 1'b0);
  endtask

  task automatic send(input logic [7:0] v, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      while (gaps && $urandom_range(0, 2) == 0) cyc(1'b0, 2'($urandom), 1'b0);
      cyc(1'b1, v[7-2*k -: 2], 1'b0);
    end
  endtask

  task automatic clear();
    got_row.delete();
    got_col.delete();
    got_v.delete();
    done_cnt = 0;
    req_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge eth_refclk);
    rst = 1'b0;
    start = 1'b0;
    valid_data_in = 1'b0;
    ready_in = rdy_nxt;
    repeat (2) @(negedge eth_refclk);
    rst = 1'b1;
    clear();
  endtask

  task automatic begin_matrix();
    cyc(1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge eth_refclk);
    rst = 1'b0;
    repeat (2) @(negedge eth_refclk);
    checks += 7;
    if (data_request !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", data_request); end
    if (valid_data_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_data_out); end
    if (row_addr !== 5'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", row_addr); end
    if (col_addr !== 5'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", col_addr); end
    if (matrix_element !== 8'd0) begin failures++; $display("FAIL reset_elem got=%h exp=00", matrix_element); end
    if (decompile_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", decompile_done); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b1;
  endtask

  task automatic test_request();
    do_reset();
    cyc(1'b0, 2'b00, 1'b1);
    checks++;
    if (data_request !== 1'b0) begin failures++; $display("FAIL req_early got=%b exp=0", data_request); end
    cyc(1'b0, 2'b00, 1'b0);
    checks++;
    if (data_request !== 1'b1) begin failures++; $display("FAIL req_pulse got=%b exp=1", data_request); end
    cyc(1'b0, 2'b00, 1'b0);
    checks++;
    if (data_request !== 1'b0) begin failures++; $display("FAIL req_end got=%b exp=0", data_request); end
    idle(3);
    checks++;
    if (req_cnt != 1) begin failures++; $display("FAIL req_count got=%0d exp=1", req_cnt); end
  endtask

  task automatic test_single();
    rdy_nxt = 1'b1;
    do_reset();
    begin_matrix();
    send(8'hB1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    checks++;
    if (valid_data_out !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", valid_data_out); end
    cyc(1'b0, 2'b00, 1'b0);
    checks += 4;
    if (valid_data_out !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid_data_out); end
    if (matrix_element !== 8'hB1) begin failures++; $display("FAIL single_elem got=%h exp=b1", matrix_element); end
    if (row_addr !== 5'd0) begin failures++; $display("FAIL single_row got=%0d exp=0", row_addr); end
    if (col_addr !== 5'd0) begin failures++; $display("FAIL single_col got=%0d exp=0", col_addr); end
  endtask

  task automatic test_full_matrix();
    int bad;
    rdy_nxt = 1'b1;
    do_reset();
    begin_matrix();
    for (int i = 0; i < N; i++) send(8'(i), 1'b1);
    for (int t = 0; t < 100 && done_cnt == 0; t++) idle(1);
    idle(5);
    checks++;
    if (got_v.size() != N) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_v.size(), N); end
    bad = 0;
    for (int i = 0; i < got_v.size() && i < N; i++) begin
      checks++;
      if (got_row[i] != i / B || got_col[i] != i % B || got_v[i] != (i & 255)) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL full_entry%0d got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", i,
                   got_row[i], got_col[i], got_v[i], i / B, i % B, i & 255);
      end
    end
    if (got_v.size() > 33) begin
      checks++;
      if (got_row[33] != 1 || got_col[33] != 1 || got_v[33] != 33) begin
        failures++;
        $display("FAIL full_elem33 got=(%0d,%0d,%0d) exp=(1,1,33)", got_row[33], got_col[33], got_v[33]);
      end
    end
    checks += 2;
    if (done_cnt != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] ov [5];
    logic [7:0] x;
    rdy_nxt = 1'b0;
    do_reset();
    begin_matrix();
    for (int i = 0; i < 5; i++) ov[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      send(ov[i], 1'b1);
      if (i == 2) cyc(1'b0, 2'b00, 1'b1);
    end
    idle(3);
    checks += 4;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (valid_data_out !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", valid_data_out); end
    if (matrix_element !== ov[0] || row_addr !== 5'd0 || col_addr !== 5'd0) begin
      failures++;
      $display("FAIL ovf_head got=(%0d,%0d,%h) exp=(0,0,%h)", row_addr, col_addr, matrix_element, ov[0]);
    end
    if (req_cnt != 1) begin failures++; $display("FAIL start_ignored got=%0d exp=1", req_cnt); end
    idle(4);
    checks++;
    if (matrix_element !== ov[0] || col_addr !== 5'd0) begin
      failures++;
      $display("FAIL ovf_stable got=(%0d,%h) exp=(0,%h)", col_addr, matrix_element, ov[0]);
    end
    rdy_nxt = 1'b1;
    idle(8);
    checks++;
    if (got_v.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", got_v.size()); end
    for (int i = 0; i < got_v.size() && i < 4; i++) begin
      checks++;
      if (got_row[i] != 0 || got_col[i] != i || got_v[i] != int'(ov[i])) begin
        failures++;
        $display("FAIL ovf_entry%0d got=(%0d,%0d,%h) exp=(0,%0d,%h)", i, got_row[i], got_col[i], got_v[i], i, ov[i]);
      end
    end
    x = 8'($urandom);
    send(x, 1'b0);
    idle(3);
    checks += 2;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    if (got_v.size() != 5 || got_col[got_col.size()-1] != 5 || got_v[got_v.size()-1] != int'(x)) begin
      failures++;
      $display("FAIL ovf_next_idx got_n=%0d exp_n=5 exp=(0,5,%h)", got_v.size(), x);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] x;
    rdy_nxt = 1'b1;
    do_reset();
    begin_matrix();
    for (int i = 0; i < 10; i++) send(8'($urandom), 1'b1);
    cyc(1'b1, 2'b11, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    do_reset();
    idle(5);
    checks += 2;
    if (valid_data_out !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid_data_out); end
    if (done_cnt != 0) begin failures++; $display("FAIL mid_done got=%0d exp=0", done_cnt); end
    x = 8'($urandom);
    begin_matrix();
    send(x, 1'b1);
    idle(3);
    checks++;
    if (got_v.size() != 1 || got_row[0] != 0 || got_col[0] != 0 || got_v[0] != int'(x)) begin
      failures++;
      $display("FAIL mid_restart got_n=%0d exp=(0,0,%h)", got_v.size(), x);
    end
  endtask

  initial begin
    test_reset();
    test_request();
    test_single();
    test_full_matrix();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_decompiler.md
MATRIX_DECOMPILER -- requirements
Module: matrix_decompiler

Interface
REQ-001 The module SHALL have parameter MAX_ELEMENT_SIZE, default 8, giving the element width in bits; only the value 8 is supported, i.e. 4 dibits per element.
REQ-002 The module SHALL have parameter MAX_SIZE_A, default 32, giving the number of matrix rows.
REQ-003 The module SHALL have parameter MAX_SIZE_B, default 32, giving the number of matrix columns; MAX_SIZE_A and MAX_SIZE_B are powers of 2.
REQ-004 Port eth_refclk, input, 1 bit: the single clock; one clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: reset is synchronous and active-low.
REQ-006 Port start, input, 1 bit: a one-cycle pulse requesting reception of one matrix.
REQ-007 Port data_request, output, 1 bit: a one-cycle pulse to the upstream transmitter to begin streaming.
REQ-008 Port valid_data_in, input, 1 bit: qualifies dibit this cycle.
REQ-009 Port dibit, input, 2 bits: received data, MSB-first within each element.
REQ-010 Port row_addr, output, $clog2(MAX_SIZE_A) bits: row of matrix_element.
REQ-011 Port col_addr, output, $clog2(MAX_SIZE_B) bits: column of matrix_element.
REQ-012 Port matrix_element, output, MAX_ELEMENT_SIZE bits: reassembled element.
REQ-013 Port valid_data_out, output, 1 bit: the row_addr/col_addr/matrix_element triple is valid.
REQ-014 Port ready_in, input, 1 bit: downstream accepts the triple when valid_data_out and ready_in are both 1.
REQ-015 Port decompile_done, output, 1 bit: one-cycle pulse when the whole matrix has been delivered.
REQ-016 Port overflow, output, 1 bit: sticky flag, an element was dropped.

Function
REQ-017 The module SHALL implement states IDLE, REQUEST, RECEIVE, DRAIN.
- IDLE to REQUEST: on start=1.
- start is ignored outside IDLE.
REQ-018 In REQUEST, data_request SHALL be 1 for exactly one cycle, after which the state SHALL become RECEIVE.
REQ-019 In RECEIVE, each cycle with valid_data_in=1 SHALL shift dibit into a 2-bit-counted assembler.
- 1st dibit lands in bits [7:6], 2nd in [5:4], 3rd in [3:2], 4th in [1:0].
REQ-020 Cycles with valid_data_in=0 SHALL hold the assembler and dibit counter unchanged (gap-tolerant).
REQ-021 On the 4th dibit, the completed element SHALL be pushed into a 4-entry FIFO on the next cycle.
- Tag: row = idx / MAX_SIZE_B, col = idx % MAX_SIZE_B.
- idx is a $clog2(MAX_SIZE_A*MAX_SIZE_B)-bit element counter starting at 0.
REQ-022 The element counter SHALL increment once per completed element, whether that element is pushed or dropped.
REQ-023 If the FIFO is full when a push is due, the element SHALL be dropped and overflow set to 1 until reset.
- A pop in the same cycle frees a slot, so the push succeeds.
REQ-024 valid_data_out SHALL equal FIFO not-empty, and the outputs SHALL present the FIFO head.
- Outputs SHALL remain stable while valid_data_out=1 and ready_in=0.
REQ-025 Simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-026 When the element with idx = MAX_SIZE_A*MAX_SIZE_B-1 completes, the state SHALL become DRAIN and further dibits SHALL be ignored.
REQ-027 In DRAIN, once the FIFO is empty, decompile_done SHALL pulse for one cycle and the state SHALL return to IDLE.
- On return, the element counter and dibit counter are cleared.
REQ-028 Latency: matrix_element SHALL be valid on the 2nd cycle after the cycle carrying the 4th dibit, when the FIFO was empty.

Reset
REQ-029 While rst=0, all state SHALL clear: state=IDLE, counters=0, FIFO empty.
REQ-030 Output reset values: data_request=0, valid_data_out=0, row_addr=0, col_addr=0, matrix_element=0, decompile_done=0, overflow=0.
REQ-031 Reset asserted mid-RECEIVE SHALL abandon the matrix; no decompile_done is produced.

Verification
REQ-032 Pulse start -> data_request=1 for exactly one cycle, then RECEIVE.
REQ-033 With ready_in=1, stream dibits 2'b10,2'b11,2'b00,2'b01 -> element 8'hB1 at row 0, col 0, two cycles after the last dibit.
REQ-034 Stream 1024 elements with value = idx[7:0], with random valid_data_in gaps and ready_in=1 -> every (row,col,element) matches, element 33 appears at row 1, col 1, then one decompile_done pulse.
REQ-035 Hold ready_in=0 while 5 elements arrive -> 4 held in order, 5th dropped, overflow=1; release ready_in -> 4 elements delivered, overflow stays 1.
REQ-036 Assert rst=0 after 2 dibits of element 10, then restart -> first output is row 0, col 0, with no stale data.
REQ-037 start pulses during RECEIVE -> ignored, no extra data_request.
